// File: rtl/gear_selector.sv
// Shift-lever front end: debounces the up/down buttons, applies brake/speed/lockout
// interlocks and registers the gear code (3=P, 6=R, 9=N, 12=D) for the physics block.
module gear_selector #(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LOCKOUT_MS  = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1ms,
  input  logic       engine_on,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       is_brake_normal,
  input  logic       is_brake_hard,
  input  logic [7:0] speed,
  output logic [3:0] current_gear,
  output logic       gear_changed,
  output logic       shift_denied,
  output logic [1:0] deny_code,
  output logic       reverse_lamp
);

  typedef enum logic [3:0] {
    GEAR_P = 4'd3,
    GEAR_R = 4'd6,
    GEAR_N = 4'd9,
    GEAR_D = 4'd12
  } gear_t;

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_MS - 1);
  localparam logic [9:0] LOCK_INIT = 10'(LOCKOUT_MS);

  // Bit 0 = up button, bit 1 = down button.
  logic [1:0] raw;
  logic [1:0] req;

  gear_t      gear, gear_next, target;
  logic [9:0] lock_cnt, lock_next;
  logic       fwd, fwd_next;
  logic       deny_next;
  logic [1:0] code_next;
  logic       end_stop;
  logic       req_up, req_dn;

  assign raw    = {btn_down_raw, btn_up_raw};
  assign req_up = req[0];
  assign req_dn = req[1];

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic       s1, s2, st, st_d;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        st   <= 1'b0;
        st_d <= 1'b0;
        cnt  <= '0;
      end else begin
        s1   <= raw[g];
        s2   <= s1;
        st_d <= st;
        if (s2 == st) begin
          cnt <= '0;
        end else if (tick_1ms) begin
          if (cnt == DB_LAST) begin
            st  <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      end
    end

    assign req[g] = st & ~st_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gear         <= GEAR_P;
      lock_cnt     <= '0;
      fwd          <= 1'b0;
      gear_changed <= 1'b0;
      shift_denied <= 1'b0;
      deny_code    <= '0;
      reverse_lamp <= 1'b0;
    end else begin
      gear         <= gear_next;
      lock_cnt     <= lock_next;
      fwd          <= fwd_next;
      gear_changed <= (gear_next != gear);
      shift_denied <= deny_next;
      deny_code    <= code_next;
      reverse_lamp <= (gear_next == GEAR_R);
    end
  end

  always_comb begin
    gear_next = gear;
    target    = gear;
    end_stop  = 1'b0;
    deny_next = 1'b0;
    code_next = deny_code;
    lock_next = (tick_1ms && lock_cnt != '0) ? lock_cnt - 10'd1 : lock_cnt;

    case (gear)
      GEAR_P: begin
        target   = GEAR_R;
        end_stop = req_up;
      end
      GEAR_R:  target = req_up ? GEAR_P : GEAR_N;
      GEAR_N:  target = req_up ? GEAR_R : GEAR_D;
      GEAR_D: begin
        target   = GEAR_N;
        end_stop = req_dn;
      end
      default: target = gear;
    endcase

    // Lockout check looks at the pre-decrement count, so a request on the final tick is still refused.
    if (!engine_on) begin
      gear_next = GEAR_P;
      lock_next = '0;
    end else if ((req_up ^ req_dn) && !end_stop) begin
      if (lock_cnt != '0) begin
        deny_next = 1'b1;
        code_next = 2'd3;
      end else if (gear == GEAR_P && !(is_brake_normal | is_brake_hard)) begin
        deny_next = 1'b1;
        code_next = 2'd1;
      end else if ((target == GEAR_P || target == GEAR_R || gear == GEAR_P) && speed != '0) begin
        deny_next = 1'b1;
        code_next = 2'd2;
      end else if (gear == GEAR_N && target == GEAR_D && speed != '0 && !fwd) begin
        deny_next = 1'b1;
        code_next = 2'd2;
      end else begin
        gear_next = target;
        lock_next = LOCK_INIT;
      end
    end

    fwd_next = fwd;
    if (gear_next == GEAR_D) begin
      fwd_next = 1'b1;
    end else if (gear_next == GEAR_P || gear_next == GEAR_R) begin
      fwd_next = 1'b0;
    end else if (gear == GEAR_N && speed == '0) begin
      fwd_next = 1'b0;
    end
  end

  always_comb begin
    current_gear = gear;
  end

endmodule

// File: doc/gear_selector.md
Name: gear_selector

Overview:
- Upstream stage of the vehicle physics block: turns two raw shift-lever buttons into the registered gear code `current_gear` (3=P, 6=R, 9=N, 12=D) that the physics block consumes.
- Debounces the buttons, enforces brake and speed interlocks and a post-shift lockout, and reports each accepted or refused shift to the dashboard/LED logic.

Parameters:
- DEBOUNCE_MS, 20, consecutive tick_1ms ticks a synchronised button level must hold before it is accepted (range 1..255).
- LOCKOUT_MS, 200, tick_1ms ticks after an accepted shift during which further requests are refused (range 1..1023).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- tick_1ms  in  1  one-clk pulse every 1 ms.
- engine_on  in  1  engine running.
- btn_up_raw  in  1  asynchronous button, lever toward P (D→N→R→P).
- btn_down_raw  in  1  asynchronous button, lever toward D (P→R→N→D).
- is_brake_normal  in  1  normal brake pressed.
- is_brake_hard  in  1  hard brake pressed.
- speed  in  8  current speed, km/h, unsigned.
- current_gear  out  4  registered gear code: 3, 6, 9 or 12 only.
- gear_changed  out  1  one-clk pulse when current_gear changes value.
- shift_denied  out  1  one-clk pulse when a request is refused.
- deny_code  out  2  reason for the last refusal, held until the next refusal: 1=no brake, 2=speed≠0, 3=lockout.
- reverse_lamp  out  1  registered; 1 iff current_gear==6.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: current_gear=3, gear_changed=0, shift_denied=0, deny_code=0, reverse_lamp=0. Synchronisers, debounce counters, stable levels, lockout counter and fwd_flag all clear to 0.
- Reset asserted mid-debounce or mid-lockout discards all progress.

Synchronising and debouncing:
- Each raw button passes through a 2-FF synchroniser.
- Each button has an 8-bit debounce counter and a stable level.
- If sync==stable, the counter clears.
- Otherwise the counter increments on tick_1ms. On the tick where it reaches DEBOUNCE_MS, stable takes the sync value and the counter clears.
- A request is a rising edge of stable (stable & ~stable_d). There is no auto-repeat; a held button gives exactly one request.

Request evaluation (registered, 1 clk after the stable edge):
- If engine_on=0, requests are ignored.
- Up and down requests in the same clk are both ignored, with no pulse.
- Up at P or down at D is ignored silently (end stop).
- Otherwise the target is the adjacent gear. Checks are applied in priority order; the first failure sets shift_denied=1 and deny_code, and the gear is unchanged:
  1. Lockout counter ≠0 → code 3.
  2. Leaving P without (is_brake_normal | is_brake_hard) → code 1.
  3. Target P, or target R, or leaving P, with speed≠0 → code 2.
  4. N→D with speed≠0 and fwd_flag=0 → code 2.
- R→N and D→N are always allowed apart from the lockout check.
- On acceptance: current_gear updates, gear_changed=1, and the lockout counter loads LOCKOUT_MS.

Lockout counter:
- 10 bits; decrements on tick_1ms when nonzero and saturates at 0.
- A request arriving in the same clk as the tick that takes the counter to 0 is still refused (the check uses the pre-decrement value).

fwd_flag:
- Set when the gear becomes D.
- Cleared when the gear becomes P or R, or when speed==0 while the gear is N.
- Purpose: allows D→N→D while coasting.

Engine off:
- While engine_on=0, current_gear is forced to 3 every clk and the lockout counter clears.
- gear_changed pulses once if the gear was not already 3.
- Debounce continues, but edges seen while the engine is off are discarded.

Output timing:
- reverse_lamp follows current_gear in the same register update.
- Pulses never exceed 1 clk, and gear_changed and shift_denied are mutually exclusive.

Test Plan:
1. Reset, engine_on=1, brake=1, speed=0; press down for 25 ms → after 20 ticks plus 1 clk: gear 3→6, gear_changed 1-clk pulse, reverse_lamp=1.
2. Gear P, brake=0, press down → shift_denied pulse, deny_code=1, gear stays 3. Repeat with brake=1, speed=5 → deny_code=2.
3. Shift to R, then press down again 100 ms later → denied, deny_code=3. Press again 210 ms after the first shift → gear 9.
4. Gear D, speed=60: up to N accepted. After 250 ms, down → back to 12 (fwd_flag). Set speed=0 in N, then speed=10, down → denied, code 2.
5. Bounce: toggle btn_down_raw every 5 ms for 50 ms, then release → no request. Press both buttons simultaneously and stably → no change, no pulses.
6. Gear D, drop engine_on → gear=3 next clk with a single gear_changed pulse. Assert rst_n=0 midway through a 15 ms press → on release of reset all outputs are at reset values and no shift occurs.
